// File: rtl/sensor_cmd_tx.sv
// UART transmitter that sends one register-write command to the wireless sensor as a
// 5-byte frame: 0xFF 0xAA addr data[7:0] data[15:8], 8N1 (or 8N2), LSB first.
module sensor_cmd_tx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 10
) (
    input  logic        clk_uart,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("sensor_cmd_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("sensor_cmd_tx: CLKS_PER_BIT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t           r_state;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       r_byte_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [7:0]       r_buf [0:4];

    logic             w_accept;
    logic             w_bit_last;
    logic [2:0]       w_next_idx;
    logic [7:0]       w_cur_byte;

    assign w_accept   = cmd_valid && r_ready;
    assign w_bit_last = (r_bit_cnt == CNT_LAST);
    assign w_next_idx = r_bit_idx + 3'd1;

    always_comb begin
        w_cur_byte = 8'hFF;
        case (r_byte_idx)
            3'd0:    w_cur_byte = r_buf[0];
            3'd1:    w_cur_byte = r_buf[1];
            3'd2:    w_cur_byte = r_buf[2];
            3'd3:    w_cur_byte = r_buf[3];
            3'd4:    w_cur_byte = r_buf[4];
            default: w_cur_byte = 8'hFF;
        endcase
    end

    // NOTE: the frame buffer is pure datapath and is only read after a load, so it has no reset.
    always_ff @(posedge clk_uart) begin
        if (w_accept) begin
            r_buf[0] <= 8'hFF;
            r_buf[1] <= 8'hAA;
            r_buf[2] <= cmd_addr;
            r_buf[3] <= cmd_data[7:0];
            r_buf[4] <= cmd_data[15:8];
        end
    end

    // tx is registered and aligned with r_state: every transition also loads the next line level.
    always_ff @(posedge clk_uart) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_gap_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_START: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= w_cur_byte[w_next_idx];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx != STOP_LAST) begin
                            r_bit_idx <= w_next_idx;
                        end else if (r_byte_idx != 3'd4) begin
                            r_bit_idx  <= '0;
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_bit_idx <= '0;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                            // A zero-length gap collapses to the single done cycle.
                            r_done    <= (GAP_BITS == 0);
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        if (w_bit_last) begin
                            r_bit_cnt <= '0;
                            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                        // Raise done one edge early so it lands in the final gap cycle.
                        if (r_gap_cnt == GAP_LAST && r_bit_cnt == CNT_PENULT) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cmd_ready = r_ready;

endmodule
